// File: rtl/median_window_feeder_if.sv
// System-side bus of median_window_feeder: image RAM read port, MEDIAN stream,
// output RAM write port and frame control.
interface median_window_feeder_if #(
  parameter int unsigned AW = 16
);
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] raddr;
  logic [7:0]    rdata;
  logic [7:0]    di;
  logic          dsi;
  logic [7:0]    mdo;
  logic          dso;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          we;

  modport master (
    input  start, rdata, mdo, dso,
    output busy, done, err, raddr, di, dsi, waddr, wdata, we
  );

  modport slave (
    output start, rdata, mdo, dso,
    input  busy, done, err, raddr, di, dsi, waddr, wdata, we
  );
endinterface

// File: rtl/median_window_feeder.sv
// Frame sequencer feeding 3x3 border-replicated windows to a serial MEDIAN unit.
// Define MEDIAN_FEEDER_TIMEOUT_EN to add the WAIT watchdog and the sticky ERR flag.
module median_window_feeder #(
  parameter int unsigned W       = 256,
  parameter int unsigned H       = 256,
  parameter int unsigned AW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  median_window_feeder_if.master bus
);

  localparam int unsigned XW = (W > 1) ? $clog2(W) : 1;
  localparam int unsigned YW = (H > 1) ? $clog2(H) : 1;
  localparam int unsigned CW = 4;

  localparam logic [XW-1:0] X_MAX      = XW'(W - 1);
  localparam logic [YW-1:0] Y_MAX      = YW'(H - 1);
  localparam logic [CW-1:0] TAP_LAST   = CW'(8);
  localparam logic [CW-1:0] DSI_LAST   = CW'(9);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(10);

  if (W < 2 || H < 2 || TIMEOUT < 1 ||
      (64'(W) * 64'(H)) > (64'(1) << AW)) begin : g_bad_cfg
    $error("median_window_feeder: illegal W/H/AW/TIMEOUT combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_WRITE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] x_q, x_d, x_nxt;
  logic [YW-1:0] y_q, y_d, y_nxt;
  logic          last_px;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [7:0]    di_q, di_d;
  logic          dsi_q, dsi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CENTRE_CYC = CW'(5);

  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [7:0]    centre_q, centre_d;
  logic          err_q, err_d;
`endif

  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] px,
                                             input logic [YW-1:0] py);
    return AW'(py) * AW'(W) + AW'(px);
  endfunction

  // Row-major tap k of the window around (px,py), clamped at the image edges
  function automatic logic [AW-1:0] tap_addr(input logic [XW-1:0] px,
                                             input logic [YW-1:0] py,
                                             input logic [CW-1:0] k);
    logic [XW-1:0] rx;
    logic [YW-1:0] ry;
    case (k)
      CW'(0), CW'(3), CW'(6): rx = (px == '0)    ? px : px - XW'(1);
      CW'(2), CW'(5), CW'(8): rx = (px == X_MAX) ? px : px + XW'(1);
      default:                rx = px;
    endcase
    case (k)
      CW'(0), CW'(1), CW'(2): ry = (py == '0)    ? py : py - YW'(1);
      CW'(6), CW'(7), CW'(8): ry = (py == Y_MAX) ? py : py + YW'(1);
      default:                ry = py;
    endcase
    return pix_addr(rx, ry);
  endfunction

  // Raster advance
  always_comb begin
    last_px = (x_q == X_MAX) && (y_q == Y_MAX);
    if (x_q == X_MAX) begin
      x_nxt = '0;
      y_nxt = y_q + YW'(1);
    end else begin
      x_nxt = x_q + XW'(1);
      y_nxt = y_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    raddr_d  = '0;
    di_d     = '0;
    dsi_d    = 1'b0;
    done_d   = 1'b0;
    we_d     = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
    wcnt_d   = '0;
    centre_d = centre_q;
    err_d    = err_q;
`endif

    // RDATA for taps 0..8 returns in window cycles 1..9
    if ((state_q == S_FETCH && cnt_q != '0) ||
        (state_q == S_DRAIN && cnt_q == DSI_LAST)) begin
      dsi_d = 1'b1;
      di_d  = bus.rdata;
    end

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
    if (state_q == S_FETCH && cnt_q == CENTRE_CYC) begin
      centre_d = bus.rdata;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          cnt_d   = '0;
          x_d     = '0;
          y_d     = '0;
          raddr_d = tap_addr('0, '0, CW'(0));
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end

      S_FETCH: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == TAP_LAST) begin
          state_d = S_DRAIN;
        end else begin
          raddr_d = tap_addr(x_q, y_q, cnt_q + CW'(1));
        end
      end

      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.dso) begin
          state_d = S_WRITE;
          we_d    = 1'b1;
          waddr_d = pix_addr(x_q, y_q);
          wdata_d = bus.mdo;
        end
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          // MEDIAN never answered: pass the centre pixel through and flag it
          state_d = S_WRITE;
          we_d    = 1'b1;
          waddr_d = pix_addr(x_q, y_q);
          wdata_d = centre_q;
          err_d   = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
`endif
      end

      S_WRITE: begin
        if (last_px) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          x_d     = '0;
          y_d     = '0;
        end else begin
          state_d = S_FETCH;
          cnt_d   = '0;
          x_d     = x_nxt;
          y_d     = y_nxt;
          raddr_d = tap_addr(x_nxt, y_nxt, CW'(0));
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      raddr_q  <= '0;
      di_q     <= '0;
      dsi_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      raddr_q  <= raddr_d;
      di_q     <= di_d;
      dsi_q    <= dsi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

`ifdef MEDIAN_FEEDER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q   <= '0;
      centre_q <= '0;
      err_q    <= 1'b0;
    end else begin
      wcnt_q   <= wcnt_d;
      centre_q <= centre_d;
      err_q    <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.raddr = raddr_q;
  assign bus.di    = di_q;
  assign bus.dsi   = dsi_q;
  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign bus.we    = we_q;

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder on a 4x4 frame with a behavioural
// image RAM and serial MEDIAN model.
module tb_median_window_feeder;

  localparam int unsigned W       = 4;
  localparam int unsigned H       = 4;
  localparam int unsigned AW      = 8;
  localparam int unsigned TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst_n;

  median_window_feeder_if #(.AW(AW)) bus ();

  median_window_feeder #(
    .W(W), .H(H), .AW(AW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Synchronous-read image RAM
  logic [7:0] mem [16];
  always @(posedge clk) bus.rdata <= mem[bus.raddr[3:0]];

  // Behavioural MEDIAN: 9 strobed samples, then DSO after lat extra cycles
  bit          med_en;
  int          lat;
  logic        dso_m, dso_inj;
  logic [7:0]  mdo_m;
  logic [71:0] win;
  int          n_s, cd;

  function automatic logic [7:0] median9(input logic [71:0] v);
    logic [7:0] a [9];
    logic [7:0] t;
    for (int i = 0; i < 9; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[4];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_s <= 0; cd <= 0; dso_m <= 1'b0; mdo_m <= '0; win <= '0;
    end else begin
      dso_m <= 1'b0;
      if (med_en && bus.dsi) begin
        win <= {win[63:0], bus.di};
        if (n_s == 8) begin
          n_s   <= 0;
          mdo_m <= median9({win[63:0], bus.di});
          if (lat == 0) dso_m <= 1'b1;
          else          cd    <= lat;
        end else begin
          n_s <= n_s + 1;
        end
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) dso_m <= 1'b1;
      end
    end
  end

  assign bus.dso = dso_m | dso_inj;
  assign bus.mdo = mdo_m;

  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  32'(bus.busy),  32'(0));
    chk({tag, "_done"},  32'(bus.done),  32'(0));
    chk({tag, "_err"},   32'(bus.err),   32'(0));
    chk({tag, "_dsi"},   32'(bus.dsi),   32'(0));
    chk({tag, "_we"},    32'(bus.we),    32'(0));
    chk({tag, "_di"},    32'(bus.di),    32'(0));
    chk({tag, "_raddr"}, 32'(bus.raddr), 32'(0));
    chk({tag, "_waddr"}, 32'(bus.waddr), 32'(0));
    chk({tag, "_wdata"}, 32'(bus.wdata), 32'(0));
  endtask

  // Leaves the bench at the falling edge inside window cycle 0
  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int ra00 [9] = '{0, 0, 1, 0, 0, 1, 4, 4, 5};
  int ra33 [9] = '{10, 11, 11, 14, 15, 15, 14, 15, 15};
  int di00 [9] = '{0, 0, 7, 0, 0, 7, 28, 28, 35};

  initial begin
    int nwe, ndone, ph;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    dso_inj   = 1'b0;
    med_en    = 1'b0;
    lat       = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7);
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Frame with pixel n = 7n, MEDIAN latency 3, stray START and DSO mid-frame
    med_en = 1'b1;
    lat    = 3;
    pulse_start();
    for (int c = 0; c < 258; c++) begin
      ph = c % 16;
      if (c < 256) begin
        chk("a_we",  32'(bus.we),  32'(ph == 15));
        chk("a_dsi", 32'(bus.dsi), 32'(ph >= 2 && ph <= 10));
        if (ph < 2 || ph > 10) chk("a_di_idle", 32'(bus.di), 32'(0));
        if (ph == 15) chk("a_waddr_order", 32'(bus.waddr), 32'(c / 16));
      end
      if (c < 9)             chk("a_raddr00", 32'(bus.raddr), 32'(ra00[c]));
      if (c >= 2 && c <= 10) chk("a_di00",    32'(bus.di),    32'(di00[c-2]));
      if (c >= 240 && c < 249) chk("a_raddr33", 32'(bus.raddr), 32'(ra33[c-240]));
      if (c == 15) chk("a_wdata00", 32'(bus.wdata), 32'(7));
      if (c == 95) begin
        chk("a_waddr11", 32'(bus.waddr), 32'(5));
        chk("a_wdata11", 32'(bus.wdata), 32'(35));
      end
      if (c == 255) begin
        chk("a_busy_last", 32'(bus.busy), 32'(1));
        chk("a_done_early", 32'(bus.done), 32'(0));
      end
      if (c == 256) begin
        chk("a_done", 32'(bus.done), 32'(1));
        chk("a_busy_fall", 32'(bus.busy), 32'(0));
      end
      if (c == 257) chk("a_done_pulse", 32'(bus.done), 32'(0));
      bus.start = (c == 40);
      dso_inj   = (c == 51);
      @(negedge clk);
    end
    bus.start = 1'b0;
    dso_inj   = 1'b0;

    // Flat 100 image with two impulses, MEDIAN latency 0
    for (int i = 0; i < 16; i++) mem[i] = 8'd100;
    mem[5]  = 8'd255;
    mem[10] = 8'd255;
    lat     = 0;
    nwe     = 0;
    ndone   = 0;
    pulse_start();
    for (int c = 0; c < 215; c++) begin
      chk("b_we", 32'(bus.we), 32'((c % 13) == 12 && c < 208));
      if (bus.we) begin
        chk("b_waddr", 32'(bus.waddr), 32'(nwe));
        chk("b_wdata", 32'(bus.wdata), 32'(100));
        nwe++;
      end
      if (bus.done) begin
        chk("b_busy_at_done", 32'(bus.busy), 32'(0));
        ndone++;
      end
      @(negedge clk);
    end
    chk("b_we_count", 32'(nwe), 32'(16));
    chk("b_done_count", 32'(ndone), 32'(1));

    // Reset in the middle of pixel (0,0), then restart from the top
    pulse_start();
    repeat (6) @(negedge clk);
    chk("c_busy_mid", 32'(bus.busy), 32'(1));
    chk("c_dsi_mid", 32'(bus.dsi), 32'(1));
    chk("c_di_mid", 32'(bus.di), 32'(100));
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("c_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int c = 0; c < 13; c++) begin
      if (c < 9) chk("c_raddr00", 32'(bus.raddr), 32'(ra00[c]));
      chk("c_we", 32'(bus.we), 32'(c == 12));
      if (c == 12) begin
        chk("c_waddr", 32'(bus.waddr), 32'(0));
        chk("c_wdata", 32'(bus.wdata), 32'(100));
      end
      @(negedge clk);
    end
    hard_reset();

    // MEDIAN silent at pixel (0,0) with centre 0x42
    for (int i = 0; i < 16; i++) mem[i] = 8'd0;
    mem[0] = 8'h42;
    med_en = 1'b0;
    pulse_start();
    for (int c = 0; c < 80; c++) begin
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
      chk("d_we", 32'(bus.we), 32'(c == 75));
      if (c == 74) chk("d_err_before", 32'(bus.err), 32'(0));
      if (c == 75) begin
        chk("d_wdata", 32'(bus.wdata), 32'(8'h42));
        chk("d_waddr", 32'(bus.waddr), 32'(0));
        chk("d_err", 32'(bus.err), 32'(1));
      end
      if (c == 79) chk("d_err_sticky", 32'(bus.err), 32'(1));
`else
      chk("d_we_none", 32'(bus.we), 32'(0));
      if (c == 79) begin
        chk("d_err_zero", 32'(bus.err), 32'(0));
        chk("d_busy_wait", 32'(bus.busy), 32'(1));
        chk("d_dsi_wait", 32'(bus.dsi), 32'(0));
      end
`endif
      @(negedge clk);
    end
`ifdef MEDIAN_FEEDER_TIMEOUT_EN
    for (int c = 0; c < 1400 && !bus.done; c++) @(negedge clk);
    chk("d_done_seen", 32'(bus.done), 32'(1));
    chk("d_err_until_start", 32'(bus.err), 32'(1));
    @(negedge clk);
    pulse_start();
    chk("d_err_cleared", 32'(bus.err), 32'(0));
`endif
    hard_reset();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, %0d of %0d checks passed", n_pass, n_tot);
    $fatal(1);
  end

endmodule
